// File: rtl/beta_fetch_unit.sv
// Beta instruction fetch/issue stage: PC sequencing, imem req/ack fetch with
// timeout trap, and the instruction handoff to the control unit.
module beta_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
  parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [2:0]  PCSEL,
  input  logic [31:0] pc_branch,
  input  logic [31:0] pc_jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        boot_armed;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic        fetch_active;
  logic        unused_target_bits;

  assign unused_target_bits = ^{pc_branch[31], pc_branch[1:0], pc_jump[1:0]};

  // The cycle fetch_err is high is a dead FETCH cycle: no request, acks ignored.
  assign fetch_active = (state == FETCH) && !fetch_err;
  assign imem_req     = fetch_active;
  assign imem_addr    = pc;
  assign instr_valid  = (state == ISSUE);
  assign pc_plus4     = {pc[31], pc[30:0] + 31'd4};

  // Supervisor bit is never set by PC+4 or branches, and JMP can only clear it.
  always_comb begin
    next_pc = ILLOP_VECTOR;
    case (PCSEL)
      3'd0:    next_pc = pc_plus4;
      3'd1:    next_pc = {pc[31], pc_branch[30:2], 2'b00};
      3'd2:    next_pc = {pc[31] & pc_jump[31], pc_jump[30:2], 2'b00};
      3'd4:    next_pc = XADR_VECTOR;
      default: next_pc = ILLOP_VECTOR;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    if (boot_armed) state_next = FETCH;
      FETCH:   if (fetch_active && imem_ack) state_next = ISSUE;
      ISSUE:   if (instr_ready) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // BOOT spans one whole clock after reset release before the first request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_armed  <= 1'b0;
      pc          <= RESET_VECTOR;
      instruction <= '0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        BOOT: boot_armed <= 1'b1;
        FETCH: begin
          if (fetch_active) begin
            if (imem_ack) begin
              instruction <= imem_rdata;
              wait_cnt    <= '0;
            end else if (wait_cnt == LAST_WAIT) begin
              fetch_err <= 1'b1;
              pc        <= ILLOP_VECTOR;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        ISSUE: if (instr_ready) pc <= next_pc;
        default: ;
      endcase
    end
  end

endmodule
